fft_peak_track: RTL and testbench

- Parametrised spectrum peak tracker for the FFT chain. Consumes one magnitude bin per valid beat from the modulus stage, frame-aligned by a last flag.
- Finds the largest and second-largest bins inside a configurable search window, excluding DC. Converts both bin indices to frequency and publishes them.
- Supports single-shot mode (armed by the start key) and continuous mode. Includes frame-length checking.

---
 rtl/fft_peak_track.sv | 223 ++++++++++++++++++++++
 tb/tb_fft_peak_track.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_track.sv
// fft_peak_track
// ---------------------------------------------------------------------------
// Spectrum peak tracker for the FFT chain. It takes one unsigned magnitude
// bin per valid beat, frame-aligned by mag_last. It finds the largest and
// second-largest bins inside [SKIP_LO, KMAX] (DC excluded) and converts
// both bin indices to frequency (idx * FREQ_STEP, saturating). It then
// publishes the results. It runs single-shot (armed by start) or
// continuously (mode_cont).
//
// Ports
//   clk_50m     in   system clock
//   rst_n       in   synchronous active-low reset
//   start       in   one-cycle rearm pulse; clears results and frame_err
//   mode_cont   in   1 = re-arm after every result, 0 = single shot
//   mag_data    in   bin magnitude (unsigned, MAG_W)
//   mag_valid   in   beat qualifier
//   mag_last    in   last bin of the frame (qualified by mag_valid)
//   peak1_freq  out  largest-peak frequency (FREQ_W)
//   peak1_mag   out  largest-peak magnitude (MAG_W)
//   peak2_freq  out  second-peak frequency (FREQ_W)
//   peak2_mag   out  second-peak magnitude (MAG_W)
//   freq_valid  out  level: published results are valid
//   freq_upd    out  one-cycle pulse when results are refreshed
//   busy        out  high while arming, searching or converting
//   frame_err   out  sticky frame-length error
// ---------------------------------------------------------------------------
module fft_peak_track #(
    parameter int MAG_W     = 16,
    parameter int NFFT      = 8192,
    parameter int IDX_W     = 13,
    parameter int SKIP_LO   = 2,
    parameter int HALF_ONLY = 1,
    parameter int FREQ_STEP = 8,
    parameter int FREQ_W    = 16
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode_cont,
    input  logic [MAG_W-1:0]  mag_data,
    input  logic              mag_valid,
    input  logic              mag_last,
    output logic [FREQ_W-1:0] peak1_freq,
    output logic [MAG_W-1:0]  peak1_mag,
    output logic [FREQ_W-1:0] peak2_freq,
    output logic [MAG_W-1:0]  peak2_mag,
    output logic              freq_valid,
    output logic              freq_upd,
    output logic              busy,
    output logic              frame_err
);

    localparam int KMAX   = (HALF_ONLY != 0) ? (NFFT / 2 - 1) : (NFFT - 1);
    localparam int PROD_W = IDX_W + $clog2(FREQ_STEP + 1);
    // One spare bit over the wider of product/output so the saturation
    // compare never truncates.
    localparam int CALC_W = ((PROD_W > FREQ_W) ? PROD_W : FREQ_W) + 1;

    localparam logic [IDX_W-1:0]  LAST_BIN = IDX_W'(NFFT - 1);
    localparam logic [IDX_W-1:0]  KMAX_BIN = IDX_W'(KMAX);
    localparam logic [IDX_W-1:0]  SKIP_BIN = IDX_W'(SKIP_LO);
    localparam logic [CALC_W-1:0] FREQ_MAX = {{(CALC_W - FREQ_W){1'b0}}, {FREQ_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SEARCH,
        S_CALC,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  bin_cnt_q, bin_cnt_d;
    logic [MAG_W-1:0]  p1_mag_q, p1_mag_d, p2_mag_q, p2_mag_d;
    logic [IDX_W-1:0]  p1_idx_q, p1_idx_d, p2_idx_q, p2_idx_d;
    logic [FREQ_W-1:0] peak1_freq_q, peak1_freq_d, peak2_freq_q, peak2_freq_d;
    logic [MAG_W-1:0]  peak1_mag_q, peak1_mag_d, peak2_mag_q, peak2_mag_d;
    logic              freq_valid_q, freq_valid_d;
    logic              frame_err_q, frame_err_d;

    logic at_end;
    logic early_last;
    logic missing_last;
    logic eligible;
    logic search_beat;

    // Full-width product, clamped to all ones when it does not fit FREQ_W.
    function automatic logic [FREQ_W-1:0] to_freq(input logic [IDX_W-1:0] idx);
        logic [CALC_W-1:0] prod;
        prod = CALC_W'(idx) * CALC_W'(FREQ_STEP);
        return (prod > FREQ_MAX) ? {FREQ_W{1'b1}} : prod[FREQ_W-1:0];
    endfunction

    assign at_end       = (bin_cnt_q == LAST_BIN);
    assign early_last   = mag_valid && mag_last && !at_end;
    assign missing_last = mag_valid && !mag_last && at_end;
    assign eligible     = (bin_cnt_q >= SKIP_BIN) && (bin_cnt_q <= KMAX_BIN);
    // The bin-0 beat that releases ARM is treated as a search beat too.
    assign search_beat  = mag_valid &&
                          ((state_q == S_SEARCH) || ((state_q == S_ARM) && (bin_cnt_q == '0)));

    always_comb begin
        state_d      = state_q;
        bin_cnt_d    = bin_cnt_q;
        p1_mag_d     = p1_mag_q;
        p1_idx_d     = p1_idx_q;
        p2_mag_d     = p2_mag_q;
        p2_idx_d     = p2_idx_q;
        peak1_freq_d = peak1_freq_q;
        peak1_mag_d  = peak1_mag_q;
        peak2_freq_d = peak2_freq_q;
        peak2_mag_d  = peak2_mag_q;
        freq_valid_d = freq_valid_q;
        frame_err_d  = frame_err_q;

        // Frame-position counter runs in every state.
        if (mag_valid) begin
            bin_cnt_d = (mag_last || at_end) ? '0 : bin_cnt_q + IDX_W'(1);
        end
        if (early_last || missing_last) begin
            frame_err_d = 1'b1;
        end

        // Strict compares: on equal magnitudes the earlier bin is kept.
        if (search_beat && eligible) begin
            if (mag_data > p1_mag_q) begin
                p2_mag_d = p1_mag_q;
                p2_idx_d = p1_idx_q;
                p1_mag_d = mag_data;
                p1_idx_d = bin_cnt_q;
            end else if (mag_data > p2_mag_q) begin
                p2_mag_d = mag_data;
                p2_idx_d = bin_cnt_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (mode_cont) state_d = S_ARM;
            end
            S_ARM: begin
                if (mag_valid && (bin_cnt_q == '0) && !early_last) state_d = S_SEARCH;
            end
            S_SEARCH: begin
                if (early_last)                 state_d = S_ARM;
                else if (mag_valid && at_end)   state_d = S_CALC;
            end
            S_CALC: begin
                // Output registers load on the way into DONE, so the DONE
                // cycle is the one that presents fresh results.
                peak1_freq_d = to_freq(p1_idx_q);
                peak2_freq_d = to_freq(p2_idx_q);
                peak1_mag_d  = p1_mag_q;
                peak2_mag_d  = p2_mag_q;
                freq_valid_d = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                state_d = mode_cont ? S_ARM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // start wins over everything, including a frame end or result load.
        if (start) begin
            state_d      = S_ARM;
            freq_valid_d = 1'b0;
            frame_err_d  = 1'b0;
            peak1_freq_d = '0;
            peak1_mag_d  = '0;
            peak2_freq_d = '0;
            peak2_mag_d  = '0;
        end

        // Every (re)entry to ARM starts the search from an empty peak set.
        if (state_d == S_ARM) begin
            p1_mag_d = '0;
            p1_idx_d = '0;
            p2_mag_d = '0;
            p2_idx_d = '0;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bin_cnt_q    <= '0;
            p1_mag_q     <= '0;
            p1_idx_q     <= '0;
            p2_mag_q     <= '0;
            p2_idx_q     <= '0;
            peak1_freq_q <= '0;
            peak1_mag_q  <= '0;
            peak2_freq_q <= '0;
            peak2_mag_q  <= '0;
            freq_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_cnt_q    <= bin_cnt_d;
            p1_mag_q     <= p1_mag_d;
            p1_idx_q     <= p1_idx_d;
            p2_mag_q     <= p2_mag_d;
            p2_idx_q     <= p2_idx_d;
            peak1_freq_q <= peak1_freq_d;
            peak1_mag_q  <= peak1_mag_d;
            peak2_freq_q <= peak2_freq_d;
            peak2_mag_q  <= peak2_mag_d;
            freq_valid_q <= freq_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign peak1_freq = peak1_freq_q;
    assign peak1_mag  = peak1_mag_q;
    assign peak2_freq = peak2_freq_q;
    assign peak2_mag  = peak2_mag_q;
    assign freq_valid = freq_valid_q;
    assign frame_err  = frame_err_q;
    assign freq_upd   = (state_q == S_DONE);
    assign busy       = (state_q == S_ARM) || (state_q == S_SEARCH) || (state_q == S_CALC);

endmodule

// File: tb/tb_fft_peak_track.sv
// Bench for fft_peak_track. Two instances share all inputs: instance A
// uses FREQ_STEP=8/FREQ_W=16, instance B uses FREQ_STEP=16/FREQ_W=8, so
// B also exercises frequency saturation. The frame-level reference model
// pushes expected results into a scoreboard; a negedge monitor pops them
// whenever freq_upd is seen.
module tb_fft_peak_track;

    localparam int NFFT = 64;
    localparam int SKIP = 2;
    localparam int KMAX = 31;

    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode_cont = 1'b0;
    logic [15:0] mag_data = '0;
    logic        mag_valid = 1'b0;
    logic        mag_last = 1'b0;

    logic [15:0] p1f_a, p1m_a, p2f_a, p2m_a, p1m_b, p2m_b;
    logic [7:0]  p1f_b, p2f_b;
    logic        fv_a, upd_a, busy_a, err_a;
    logic        fv_b, upd_b, busy_b, err_b;

    fft_peak_track #(.MAG_W(16), .NFFT(64), .IDX_W(6), .SKIP_LO(2), .HALF_ONLY(1),
                     .FREQ_STEP(8), .FREQ_W(16)) dut_a (
        .clk_50m(clk_50m), .rst_n(rst_n), .start(start), .mode_cont(mode_cont),
        .mag_data(mag_data), .mag_valid(mag_valid), .mag_last(mag_last),
        .peak1_freq(p1f_a), .peak1_mag(p1m_a), .peak2_freq(p2f_a), .peak2_mag(p2m_a),
        .freq_valid(fv_a), .freq_upd(upd_a), .busy(busy_a), .frame_err(err_a));

    fft_peak_track #(.MAG_W(16), .NFFT(64), .IDX_W(6), .SKIP_LO(2), .HALF_ONLY(1),
                     .FREQ_STEP(16), .FREQ_W(8)) dut_b (
        .clk_50m(clk_50m), .rst_n(rst_n), .start(start), .mode_cont(mode_cont),
        .mag_data(mag_data), .mag_valid(mag_valid), .mag_last(mag_last),
        .peak1_freq(p1f_b), .peak1_mag(p1m_b), .peak2_freq(p2f_b), .peak2_mag(p2m_b),
        .freq_valid(fv_b), .freq_upd(upd_b), .busy(busy_b), .frame_err(err_b));

    always #5 clk_50m = ~clk_50m;

    longint cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint cyc;
        int p1f, p1m, p2f, p2m, p1fb, p2fb;
    } exp_t;
    exp_t sb_q[$];

    // Frame-level model state
    bit m_armed = 0, m_cont = 0, m_valid = 0, m_err = 0;
    int m_p1f = 0, m_p1m = 0, m_p2f = 0, m_p2m = 0, m_p1fb = 0, m_p2fb = 0;
    int fr [NFFT];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_freq(input int idx, input int stp, input int w);
        int p;
        int mx;
        p  = idx * stp;
        mx = (1 << w) - 1;
        return (p > mx) ? mx : p;
    endfunction

    // Largest eligible bin (earliest on ties), then the largest of the rest;
    // zero magnitudes never qualify, so an empty pick reports index 0.
    task automatic ref_peaks(output int i1, output int m1, output int i2, output int m2);
        i1 = 0; m1 = 0; i2 = 0; m2 = 0;
        for (int k = SKIP; k <= KMAX; k++)
            if (fr[k] > m1) begin m1 = fr[k]; i1 = k; end
        for (int k = SKIP; k <= KMAX; k++)
            if (!(m1 > 0 && k == i1) && fr[k] > m2) begin m2 = fr[k]; i2 = k; end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic l, input logic s);
        @(posedge clk_50m);
        #1;
        mag_valid = v;
        mag_data  = d;
        mag_last  = l;
        start     = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic level_check(input string tag);
        @(negedge clk_50m);
        chk({tag, "_valid_a"}, fv_a, m_valid);
        chk({tag, "_valid_b"}, fv_b, m_valid);
        chk({tag, "_err_a"}, err_a, m_err);
        chk({tag, "_err_b"}, err_b, m_err);
        chk({tag, "_busy_a"}, busy_a, m_armed);
        chk({tag, "_p1f_a"}, p1f_a, m_p1f);
        chk({tag, "_p1m_a"}, p1m_a, m_p1m);
        chk({tag, "_p2f_a"}, p2f_a, m_p2f);
        chk({tag, "_p2m_a"}, p2m_a, m_p2m);
        chk({tag, "_p1f_b"}, p1f_b, m_p1fb);
        chk({tag, "_p2f_b"}, p2f_b, m_p2fb);
    endtask

    task automatic model_start();
        m_armed = 1; m_valid = 0; m_err = 0;
        m_p1f = 0; m_p1m = 0; m_p2f = 0; m_p2m = 0; m_p1fb = 0; m_p2fb = 0;
    endtask

    task automatic do_start(input string tag);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        idle(1);
        model_start();
        level_check(tag);
    endtask

    task automatic set_mode(input bit c);
        idle(1);
        mode_cont = c;
        m_cont = c;
        if (c) m_armed = 1;
        idle(2);
    endtask

    // last_at: 63 normal, 64 = no mag_last at all, <63 early last.
    // start_at: -1 none, else bin index carrying a start pulse.
    task automatic run_frame(input string tag, input int last_at, input int start_at);
        int i1, m1, i2, m2;
        bit accept;
        exp_t e;
        m_armed = m_armed || m_cont;
        accept  = m_armed && (start_at < 0) && (last_at >= 63);
        ref_peaks(i1, m1, i2, m2);
        e.cyc  = 0;
        e.p1f  = ref_freq(i1, 8, 16);
        e.p1m  = m1;
        e.p2f  = ref_freq(i2, 8, 16);
        e.p2m  = m2;
        e.p1fb = ref_freq(i1, 16, 8);
        e.p2fb = ref_freq(i2, 16, 8);
        for (int k = 0; k < NFFT; k++) begin
            if (k > last_at) break;
            if ($urandom_range(0, 4) == 0 && k != start_at + 1) idle($urandom_range(1, 2));
            step(1'b1, 16'(fr[k]), k == last_at, k == start_at);
            if (k == 63 && accept) begin
                e.cyc = cyc + 2;
                sb_q.push_back(e);
            end
            if (start_at >= 0 && k == start_at + 1) begin
                @(negedge clk_50m);
                chk({tag, "_start_drop_valid"}, fv_a, 0);
                chk({tag, "_start_busy"}, busy_a, 1);
            end
        end
        if (start_at >= 0) begin
            model_start();
        end else begin
            if (last_at != 63) m_err = 1;
            if (accept) begin
                m_valid = 1;
                m_p1f = e.p1f; m_p1m = e.p1m; m_p2f = e.p2f; m_p2m = e.p2m;
                m_p1fb = e.p1fb; m_p2fb = e.p2fb;
                m_armed = m_cont;
            end
        end
        idle($urandom_range(3, 6));
        level_check(tag);
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < NFFT; k++) fr[k] = v;
    endtask

    task automatic fill_rand(input int hi);
        for (int k = 0; k < NFFT; k++) fr[k] = $urandom_range(0, hi);
    endtask

    // Scoreboard monitor
    always @(negedge clk_50m) begin
        if (rst_n && (upd_a || upd_b)) begin
            if (sb_q.size() == 0) begin
                chk("spurious_upd", {upd_a, upd_b}, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("upd_cycle", cyc, e.cyc);
                chk("upd_sync_b", upd_b, upd_a);
                chk("upd_valid", fv_a, 1);
                chk("upd_p1f_a", p1f_a, e.p1f);
                chk("upd_p1m_a", p1m_a, e.p1m);
                chk("upd_p2f_a", p2f_a, e.p2f);
                chk("upd_p2m_a", p2m_a, e.p2m);
                chk("upd_p1f_b", p1f_b, e.p1fb);
                chk("upd_p2f_b", p2f_b, e.p2fb);
                $display("upd @%0d: p1 %0d/%0d p2 %0d/%0d (B %0d %0d)",
                         cyc, p1f_a, p1m_a, p2f_a, p2m_a, p1f_b, p2f_b);
            end
        end
    end

    initial begin
        // Reset
        idle(3);
        @(negedge clk_50m);
        chk("rst_valid", fv_a, 0);
        chk("rst_upd", upd_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_p1f", p1f_a, 0);
        chk("rst_p2m", p2m_a, 0);
        @(posedge clk_50m);
        #1 rst_n = 1'b1;
        idle(2);
        level_check("post_rst");

        // Unarmed single-shot: frame ignored
        fill_rand(1000);
        run_frame("unarmed", 63, -1);

        // Single-shot peak
        do_start("start1");
        fill(10); fr[5] = 900; fr[12] = 400; fr[1] = 5000;
        run_frame("single", 63, -1);
        fill_rand(2000);
        run_frame("single_again", 63, -1);

        // Window and ties
        do_start("start2");
        fill(10); fr[7] = 700; fr[9] = 700; fr[40] = 9999;
        run_frame("ties", 63, -1);

        // Continuous mode, peaks at 3, 20, 31
        set_mode(1);
        fill_rand(500); fr[3] = 2000;
        run_frame("cont3", 63, -1);
        fill_rand(500); fr[20] = 2000;
        run_frame("cont20", 63, -1);
        fill_rand(500); fr[31] = 2000;
        run_frame("cont31", 63, -1);

        // Early last, then a clean frame
        fill_rand(800);
        run_frame("early_last", 40, -1);
        fill_rand(800);
        run_frame("after_early", 63, -1);

        // Start mid-search, then a full frame
        fill_rand(800);
        run_frame("start_mid", 63, 30);
        fill_rand(800);
        run_frame("after_start", 63, -1);

        // Missing last, frame accepted
        fill_rand(800);
        run_frame("no_last", 64, -1);

        // All eligible bins zero
        fill(0); fr[0] = 77; fr[1] = 88; fr[40] = 99;
        run_frame("zeros", 63, -1);

        // Leave continuous: one more result, then idle
        set_mode(0);
        fill_rand(800);
        run_frame("last_cont", 63, -1);
        fill_rand(800);
        run_frame("idle_again", 63, -1);

        // Randomized frames
        for (int r = 0; r < 12; r++) begin
            int sel;
            int hi;
            int la;
            if ($urandom_range(0, 3) == 0) set_mode(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) do_start("rnd_start");
            sel = $urandom_range(0, 9);
            hi  = (sel == 0) ? 0 : (sel < 3) ? 3 : (sel < 5) ? 50 : 65535;
            fill_rand(hi);
            sel = $urandom_range(0, 9);
            la  = (sel == 0) ? $urandom_range(10, 62) : (sel == 1) ? 64 : 63;
            run_frame("rnd", la, -1);
        end

        idle(8);
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
